tt_vcpop_iter: RTL

TT_VCPOP_ITER -- requirements
Module: tt_vcpop_iter

---
 rtl/tt_vcpop_pkg.sv | 15 +
 rtl/tt_popcnt.sv | 16 +
 rtl/tt_vcpop_iter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/tt_vcpop_pkg.sv
// rtl/tt_vcpop_pkg.sv - shared enums for the iterative mask popcount / find-first unit
package tt_vcpop_pkg;

  typedef enum logic {
    POPCNT = 1'b0,
    FIRST  = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/tt_popcnt.sv
// rtl/tt_popcnt.sv - combinational population count of one WIDTH-bit slice
module tt_popcnt #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0]       i_data,
  output logic [$clog2(WIDTH):0] o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_count = o_count + {{$clog2(WIDTH){1'b0}}, i_data[i]};
    end
  end

endmodule

// File: rtl/tt_vcpop_iter.sv
// rtl/tt_vcpop_iter.sv - vcpop.m / vfirst.m evaluated CHUNK bits per cycle
module tt_vcpop_iter
  import tt_vcpop_pkg::*;
#(
  parameter int  WIDTH  = 256,
  parameter int  CHUNK  = 64,
  localparam int SIZE   = $clog2(WIDTH),
  localparam int NCHUNK = WIDTH / CHUNK
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            i_mode,
  input  logic [WIDTH-1:0] i_data,
  input  logic [WIDTH-1:0] i_v0,
  input  logic            i_use_v0,
  input  logic [SIZE:0]   i_vl,
  input  logic            i_kill,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [SIZE:0]   o_count,
  output logic [SIZE-1:0] o_first_idx,
  output logic            o_first_found
);

  localparam int CW = $clog2(CHUNK);
  localparam int KW = $clog2(NCHUNK) + 1;

  state_t           state;
  mode_t            mode_q;
  logic [WIDTH-1:0] eff_q;
  logic [WIDTH-1:0] eff_in;
  logic [WIDTH-1:0] vl_mask;
  logic [KW-1:0]    k;
  logic [KW-1:0]    nact;
  logic [KW-1:0]    nact_in;
  logic [SIZE:0]    acc;
  logic [SIZE:0]    acc_nxt;
  logic [CHUNK-1:0] chunk;
  logic [CW:0]      chunk_cnt;
  logic [CW-1:0]    lsb_idx;
  logic             chunk_any;
  logic             last_chunk;
  logic [SIZE-1:0]  first_idx;
  logic             accept;

  assign o_ready = (state == IDLE) || (state == DONE && i_ready && !i_kill);
  assign accept  = i_valid && o_ready && !i_kill;

  always_comb begin
    vl_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      vl_mask[i] = ((SIZE+1)'(i) < i_vl);
    end
    eff_in = i_data & (i_use_v0 ? i_v0 : {WIDTH{1'b1}}) & vl_mask;
  end

  // Number of chunks that can hold an active element: ceil(vl / CHUNK).
  assign nact_in = KW'((i_vl + (SIZE+1)'(CHUNK - 1)) >> CW);

  // The latched mask is shifted down each BUSY cycle, so chunk k is always the low slice.
  assign chunk = eff_q[CHUNK-1:0];

  tt_popcnt #(
    .WIDTH (CHUNK)
  ) u_popcnt (
    .i_data  (chunk),
    .o_count (chunk_cnt)
  );

  always_comb begin
    lsb_idx = '0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (chunk[i]) lsb_idx = CW'(i);
    end
  end

  assign chunk_any  = |chunk;
  assign acc_nxt    = acc + (SIZE+1)'(chunk_cnt);
  assign last_chunk = (k == nact - KW'(1));
  assign first_idx  = SIZE'(int'(k) * CHUNK) + SIZE'(lsb_idx);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= IDLE;
      mode_q        <= POPCNT;
      eff_q         <= '0;
      nact          <= '0;
      k             <= '0;
      acc           <= '0;
      o_valid       <= 1'b0;
      o_count       <= '0;
      o_first_idx   <= '0;
      o_first_found <= 1'b0;
    end else if (i_kill) begin
      state   <= IDLE;
      o_valid <= 1'b0;
      k       <= '0;
    end else if (accept) begin
      eff_q  <= eff_in;
      mode_q <= mode_t'(i_mode);
      nact   <= nact_in;
      acc    <= '0;
      k      <= '0;
      if (i_vl == '0) begin
        state         <= DONE;
        o_valid       <= 1'b1;
        o_count       <= '0;
        o_first_found <= 1'b0;
      end else begin
        state   <= BUSY;
        o_valid <= 1'b0;
      end
    end else begin
      case (state)
        BUSY: begin
          acc   <= acc_nxt;
          k     <= k + KW'(1);
          eff_q <= eff_q >> CHUNK;
          // vfirst stops at the first chunk holding an active set bit.
          if (mode_q == FIRST && chunk_any) begin
            state         <= DONE;
            o_valid       <= 1'b1;
            o_count       <= acc_nxt;
            o_first_found <= 1'b1;
            o_first_idx   <= first_idx;
          end else if (last_chunk) begin
            state         <= DONE;
            o_valid       <= 1'b1;
            o_count       <= acc_nxt;
            o_first_found <= 1'b0;
          end
        end
        DONE: begin
          if (i_ready) begin
            state   <= IDLE;
            o_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
